// File: rtl/fetch_execute_sequencer.sv
// Multi-cycle accumulator CPU sequencer: fetches 16-bit instructions from a
// synchronous-read memory and steps them through FETCH/CAPTURE/DECODE/EXECUTE.
module fetch_execute_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    output logic [15:0] acc,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXECUTE = 3'd4,
        ST_HALTED  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_HALT  = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_JZ    = 4'h9,
        OP_SHL   = 4'hA,
        OP_SHR   = 4'hB,
        OP_CLR   = 4'hC
    } opcode_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_SHL = 4'b0100;
    localparam logic [3:0] ALU_SHR = 4'b0101;

    state_t      state_q;
    logic [15:0] acc_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic        halted_q;
    logic        illegal_q;

    opcode_t     opcode;
    logic [15:0] operand;
    logic [15:0] pc_d;
    logic        mem_we_d;

    assign opcode  = opcode_t'(ir_q[15:12]);
    assign operand = {4'h0, ir_q[11:0]};
    assign pc_d    = pc_q + 16'd1;

    assign acc       = acc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign mem_wdata = acc_q;
    assign alu_a     = acc_q;
    assign alu_b     = mem_rdata;

    // Memory-operand opcodes that use the ALU in EXECUTE; everything else adds.
    function automatic logic [3:0] mem_alu_op(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_mem_read_op(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND)  || (op == OP_OR)  || (op == OP_XOR);
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_addr = 16'h0000;
        mem_we_d = 1'b0;
        alu_op   = ALU_ADD;
        case (state_q)
            ST_FETCH: mem_addr = pc_q;
            ST_DECODE: begin
                if (is_mem_read_op(opcode)) begin
                    mem_addr = operand;
                end else if (opcode == OP_STORE) begin
                    mem_addr = operand;
                    mem_we_d = 1'b1;
                end else if (opcode == OP_SHL) begin
                    alu_op = ALU_SHL;
                end else if (opcode == OP_SHR) begin
                    alu_op = ALU_SHR;
                end
            end
            ST_EXECUTE: alu_op = mem_alu_op(opcode);
            default: ;
        endcase
    end

    // A reset arriving during a STORE decode must not let the write escape.
    assign mem_we = mem_we_d & ~reset;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= 16'h0000;
            pc_q      <= 16'h0000;
            ir_q      <= 16'h0000;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_d;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            state_q <= ST_EXECUTE;
                        end
                        OP_STORE: state_q <= ST_FETCH;
                        OP_JMP: begin
                            pc_q    <= operand;
                            state_q <= ST_FETCH;
                        end
                        OP_JZ: begin
                            if (acc_q == 16'h0000) begin
                                pc_q <= operand;
                            end
                            state_q <= ST_FETCH;
                        end
                        OP_SHL, OP_SHR: begin
                            acc_q   <= alu_result;
                            state_q <= ST_FETCH;
                        end
                        OP_CLR: begin
                            acc_q   <= 16'h0000;
                            state_q <= ST_FETCH;
                        end
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALTED;
                        end
                        default: begin
                            halted_q  <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= ST_HALTED;
                        end
                    endcase
                end
                ST_EXECUTE: begin
                    if (opcode == OP_LOAD) begin
                        acc_q <= mem_rdata;
                    end else begin
                        acc_q <= alu_result;
                    end
                    state_q <= ST_FETCH;
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_execute_sequencer.sv
// Directed bench: synchronous-read memory and ALU models around the sequencer,
// with small programs whose register values are hand-computed per cycle.
module tb_fetch_execute_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [15:0] acc;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;

    logic [15:0] mem [0:255];
    int compared = 0;
    int mismatched = 0;

    fetch_execute_sequencer dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .acc(acc), .pc(pc), .ir(ir), .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
    end

    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b1000: alu_result = alu_a & alu_b;
            4'b1001: alu_result = alu_a | alu_b;
            4'b1010: alu_result = alu_a ^ alu_b;
            4'b0100: alu_result = alu_a << 1;
            4'b0101: alu_result = alu_a >> 1;
            default: alu_result = 16'hDEAD;
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        run   = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        reset = 1'b1;
        run   = 1'b1;
        #1;
        cmp("reset_mem_we_comb", {15'd0, mem_we}, 16'h0000);
        step(1);
        cmp("reset_state", {13'd0, state}, 16'h0000);
        cmp("reset_acc", acc, 16'h0000);
        cmp("reset_pc", pc, 16'h0000);
        cmp("reset_ir", ir, 16'h0000);
        cmp("reset_flags", {14'd0, halted, illegal}, 16'h0000);
        cmp("reset_mem_addr", mem_addr, 16'h0000);
        reset = 1'b0;
        run   = 1'b0;
        step(2);
        cmp("idle_hold_without_run", {13'd0, state}, 16'h0000);
    endtask

    task automatic test_program();
        int n = 0;
        int we_cycles = 0;
        clear_mem();
        mem[8'h00] = 16'h1010;
        mem[8'h01] = 16'h3011;
        mem[8'h02] = 16'h2012;
        mem[8'h03] = 16'h0000;
        mem[8'h10] = 16'h0005;
        mem[8'h11] = 16'h0003;
        apply_reset();
        run = 1'b1;
        while (state !== 3'd5 && n < 50) begin
            step(1);
            n++;
            if (mem_we === 1'b1) we_cycles++;
        end
        cmp("prog_cycles_to_halted", n[15:0], 16'd15);
        cmp("prog_store_cycles", we_cycles[15:0], 16'd1);
        cmp("prog_mem12", mem[8'h12], 16'h0008);
        cmp("prog_acc", acc, 16'h0008);
        cmp("prog_pc", pc, 16'h0004);
        cmp("prog_flags", {14'd0, halted, illegal}, 16'h0002);
        step(4);
        cmp("prog_halted_hold_state", {13'd0, state}, 16'h0005);
        cmp("prog_halted_hold_pc", pc, 16'h0004);
        run = 1'b0;
    endtask

    task automatic test_jz();
        clear_mem();
        mem[8'h00] = 16'h9020;
        mem[8'h20] = 16'h1010;
        mem[8'h21] = 16'h8000;
        mem[8'h10] = 16'h0001;
        mem[8'h01] = 16'h0000;
        apply_reset();
        start();
        step(2);
        cmp("jz_decode_state", {13'd0, state}, 16'h0003);
        step(1);
        cmp("jz_taken_pc", pc, 16'h0020);
        cmp("jz_taken_state", {13'd0, state}, 16'h0001);
        step(4);
        cmp("jz_load_acc", acc, 16'h0001);
        step(3);
        cmp("jmp_pc", pc, 16'h0000);
        step(3);
        cmp("jz_not_taken_pc", pc, 16'h0001);
        cmp("jz_not_taken_state", {13'd0, state}, 16'h0001);
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[8'h00] = 16'hD123;
        apply_reset();
        start();
        step(2);
        cmp("illegal_not_yet_halted", {13'd0, state}, 16'h0003);
        step(1);
        cmp("illegal_state", {13'd0, state}, 16'h0005);
        cmp("illegal_flags", {14'd0, halted, illegal}, 16'h0003);
        cmp("illegal_pc", pc, 16'h0001);
        cmp("illegal_acc", acc, 16'h0000);
        run = 1'b1;
        step(3);
        run = 1'b0;
        step(1);
        cmp("illegal_run_ignored", {13'd0, state}, 16'h0005);
        cmp("illegal_run_pc", pc, 16'h0001);
    endtask

    task automatic test_shift_clear();
        clear_mem();
        mem[8'h00] = 16'h1010;
        mem[8'h10] = 16'h8001;
        mem[8'h01] = 16'hA000;
        mem[8'h02] = 16'hB000;
        mem[8'h03] = 16'hC000;
        mem[8'h04] = 16'h0000;
        apply_reset();
        start();
        step(4);
        cmp("shift_load_acc", acc, 16'h8001);
        step(2);
        cmp("shl_alu_op", {12'd0, alu_op}, 16'h0004);
        step(1);
        cmp("shl_acc", acc, 16'h0002);
        step(2);
        cmp("shr_alu_op", {12'd0, alu_op}, 16'h0005);
        step(1);
        cmp("shr_acc", acc, 16'h0001);
        step(3);
        cmp("clr_acc", acc, 16'h0000);
        step(3);
        cmp("shift_halted", {13'd0, state}, 16'h0005);
    endtask

    task automatic test_alu_ops();
        clear_mem();
        mem[8'h00] = 16'h1010;
        mem[8'h01] = 16'h4011;
        mem[8'h02] = 16'h5011;
        mem[8'h03] = 16'h6011;
        mem[8'h04] = 16'h7010;
        mem[8'h05] = 16'h0000;
        mem[8'h10] = 16'h0F0F;
        mem[8'h11] = 16'h00FF;
        apply_reset();
        start();
        step(4);
        cmp("alu_load_acc", acc, 16'h0F0F);
        step(2);
        cmp("sub_decode_addr", mem_addr, 16'h0011);
        step(1);
        cmp("sub_exec_alu_op", {12'd0, alu_op}, 16'h0001);
        step(1);
        cmp("sub_acc", acc, 16'h0E10);
        step(3);
        cmp("and_exec_alu_op", {12'd0, alu_op}, 16'h0008);
        step(1);
        cmp("and_acc", acc, 16'h0010);
        step(4);
        cmp("or_acc", acc, 16'h00FF);
        step(4);
        cmp("xor_acc", acc, 16'h0FF0);
        step(3);
        cmp("alu_halted", {13'd0, state}, 16'h0005);
    endtask

    task automatic test_reset_during_store();
        clear_mem();
        mem[8'h00] = 16'h1010;
        mem[8'h01] = 16'h2012;
        mem[8'h10] = 16'h0005;
        mem[8'h12] = 16'hBEEF;
        apply_reset();
        start();
        step(6);
        cmp("store_decode_state", {13'd0, state}, 16'h0003);
        cmp("store_decode_we", {15'd0, mem_we}, 16'h0001);
        cmp("store_decode_addr", mem_addr, 16'h0012);
        reset = 1'b1;
        #1;
        cmp("store_reset_we", {15'd0, mem_we}, 16'h0000);
        step(1);
        reset = 1'b0;
        cmp("store_reset_state", {13'd0, state}, 16'h0000);
        cmp("store_reset_acc", acc, 16'h0000);
        cmp("store_reset_pc", pc, 16'h0000);
        cmp("store_mem12_unchanged", mem[8'h12], 16'hBEEF);
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        test_reset();
        test_program();
        test_jz();
        test_illegal();
        test_shift_clear();
        test_alu_ops();
        test_reset_during_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
